// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N_REQ producers
// Two-state FSM: IDLE picks the next owner (one-cycle bubble), OWN passes the owner's data straight through.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write_en,
  output logic [DATA_W-1:0]         fifo_write_data,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy
);

  localparam int OWNER_W = $clog2(N_REQ);
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(N_REQ - 1);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [OWNER_W-1:0]   pick;
  logic [OWNER_W-1:0]   scan_idx;
  logic                 owner_req;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick     = rr_ptr_q;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = OWNER_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req[scan_idx]) pick = scan_idx;
    end
  end

  assign owner_req = req[owner_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    burst_cnt_d     = burst_cnt_q;
    gnt             = '0;
    fifo_write_en   = 1'b0;
    fifo_write_data = '0;
    owner           = '0;
    busy            = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = OWN;
        end
      end
      OWN: begin
        busy            = 1'b1;
        owner           = owner_q;
        fifo_write_data = req_data[owner_q*DATA_W +: DATA_W];
        fifo_write_en   = owner_req && !fifo_full;
        gnt[owner_q]    = fifo_write_en;
        if (fifo_write_en) burst_cnt_d = burst_cnt_q + BURST_W'(1);
        // A stall (full with req held) keeps the tenure; only a drop or the last beat ends it.
        if (!owner_req || (fifo_write_en && burst_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset cycle aborts any tenure: nothing may be written or advertised.
    if (rst) begin
      gnt             = '0;
      fifo_write_en   = 1'b0;
      fifo_write_data = '0;
      owner           = '0;
      busy            = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector table, corner sequences and random scoreboard run for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_write_en;
  logic [DW-1:0]   fifo_write_data;
  logic [1:0]      owner;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_full       (fifo_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .owner           (owner),
    .busy            (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        wen;
    logic [3:0]  wdata;
    logic [1:0]  owner;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_rows(input int n, input logic r, input logic [3:0] rq, input logic f,
                                   input logic [3:0] g, input logic w, input logic [3:0] wd,
                                   input logic [1:0] o, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.data = 16'h4321;
    v.gnt = g; v.wen = w; v.wdata = wd; v.owner = o; v.busy = b;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; req = v.req; fifo_full = v.full; req_data = v.data;
    #1;
    checks++;
    if ({gnt, fifo_write_en, fifo_write_data, owner, busy} !== {v.gnt, v.wen, v.wdata, v.owner, v.busy}) begin
      errors++;
      $display("FAIL %s: got gnt=%b wen=%b data=%h owner=%0d busy=%b, expected gnt=%b wen=%b data=%h owner=%0d busy=%b",
               name, gnt, fifo_write_en, fifo_write_data, owner, busy, v.gnt, v.wen, v.wdata, v.owner, v.busy);
    end
  endtask

  task automatic s(input string name, input logic r, input logic [3:0] rq, input logic f,
                   input logic [3:0] g, input logic w, input logic [3:0] wd,
                   input logic [1:0] o, input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.data = 16'h4321;
    v.gnt = g; v.wen = w; v.wdata = wd; v.owner = o; v.busy = b;
    step(v, name);
  endtask

  // Reference model state: m_own = -1 means no producer holds the port.
  int m_own, m_cnt, m_ptr;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  logic [3:0] pdata [N];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;

    // Single requester held: bubble + 4 writes repeating, owner always 0.
    add_rows(1, 1, 4'b0001, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    for (int t = 0; t < 3; t++) begin
      add_rows(1, 0, 4'b0001, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
      add_rows(4, 0, 4'b0001, 0, 4'b0001, 1, 4'h1, 2'd0, 1);
    end
    // All four requesting from reset: P0,P1,P2,P3,P0, each 4 writes after one bubble.
    add_rows(1, 1, 4'b1111, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    for (int t = 0; t < 5; t++) begin
      add_rows(1, 0, 4'b1111, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
      add_rows(4, 0, 4'b1111, 0, 4'(1 << (t % 4)), 1, 4'((t % 4) + 1), 2'(t % 4), 1);
    end
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("table[%0d]", i));

    // P2 stalls by full for 3 cycles mid-burst, finishes 3 more writes, rr_ptr lands on 3.
    s("stall_rst",    1, 4'b0100, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("stall_bubble", 0, 4'b0100, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("stall_wr0",    0, 4'b0100, 0, 4'b0100, 1, 4'h3, 2'd2, 1);
    for (int i = 0; i < 3; i++) s("stall_full", 0, 4'b0100, 1, 4'b0000, 0, 4'h3, 2'd2, 1);
    for (int i = 0; i < 3; i++) s("stall_resume", 0, 4'b0100, 0, 4'b0100, 1, 4'h3, 2'd2, 1);
    s("stall_exit_bubble", 0, 4'b1001, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("stall_next_p3",     0, 4'b1001, 0, 4'b1000, 1, 4'h4, 2'd3, 1);

    // P1 drops after 2 writes while P3 waits.
    s("drop_rst",    1, 4'b0010, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("drop_bubble", 0, 4'b0010, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("drop_wr",     0, 4'b1010, 0, 4'b0010, 1, 4'h2, 2'd1, 1);
    s("drop_wr",     0, 4'b1010, 0, 4'b0010, 1, 4'h2, 2'd1, 1);
    s("drop_exit",   0, 4'b1000, 0, 4'b0000, 0, 4'h2, 2'd1, 1);
    s("drop_bubble2", 0, 4'b1000, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("drop_p3",     0, 4'b1000, 0, 4'b1000, 1, 4'h4, 2'd3, 1);

    // Drop while stalled: tenure ends with no write.
    s("stall_drop_wr",   0, 4'b1000, 1, 4'b0000, 0, 4'h4, 2'd3, 1);
    s("stall_drop_exit", 0, 4'b0000, 1, 4'b0000, 0, 4'h4, 2'd3, 1);
    s("stall_drop_idle", 0, 4'b0000, 0, 4'b0000, 0, 4'h0, 2'd0, 0);

    // Reset mid-burst of P3, then P1 wins from rr_ptr=0.
    s("mrst_rst",    1, 4'b1000, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("mrst_bubble", 0, 4'b1000, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("mrst_wr",     0, 4'b1000, 0, 4'b1000, 1, 4'h4, 2'd3, 1);
    s("mrst_wr",     0, 4'b1000, 0, 4'b1000, 1, 4'h4, 2'd3, 1);
    s("mrst_abort",  1, 4'b1000, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("mrst_after",  0, 4'b1010, 0, 4'b0000, 0, 4'h0, 2'd0, 0);
    s("mrst_p1",     0, 4'b1010, 0, 4'b0010, 1, 4'h2, 2'd1, 1);

    // Random run against the behavioural model with an in-order FIFO scoreboard.
    m_own = -1; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) pdata[i] = 4'($urandom);
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic        r, f, w;
      logic [3:0]  rq, eg, ewd;
      logic [1:0]  eo;
      logic        eb, found;
      logic [15:0] rd;
      @(negedge clk);
      r  = (cyc == 0) || ($urandom_range(0, 63) == 0);
      f  = ($urandom_range(0, 9) < 3);
      rq = req;
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          if ($urandom_range(0, 7) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
        end
        rd[i*4 +: 4] = pdata[i];
      end
      rst = r; req = rq; fifo_full = f; req_data = rd;
      #1;

      w = 1'b0; eg = '0; ewd = '0; eo = '0; eb = 1'b0;
      if (!r && m_own >= 0) begin
        w   = rq[m_own] && !f;
        eg  = w ? 4'(1 << m_own) : 4'b0000;
        ewd = rd[m_own*4 +: 4];
        eo  = 2'(m_own);
        eb  = 1'b1;
      end
      checks++;
      if ({gnt, fifo_write_en, fifo_write_data, owner, busy} !== {eg, w, ewd, eo, eb}) begin
        errors++;
        $display("FAIL random[%0d]: got gnt=%b wen=%b data=%h owner=%0d busy=%b, expected gnt=%b wen=%b data=%h owner=%0d busy=%b",
                 cyc, gnt, fifo_write_en, fifo_write_data, owner, busy, eg, w, ewd, eo, eb);
      end
      if (f) begin
        checks++;
        if (fifo_write_en !== 1'b0) begin
          errors++;
          $display("FAIL write_while_full[%0d]: got wen=%b, expected 0", cyc, fifo_write_en);
        end
      end
      if (w) exp_q.push_back(ewd);
      if (fifo_write_en) got_q.push_back(fifo_write_data);

      // Producers hold data until accepted; a fresh word follows each grant.
      for (int i = 0; i < N; i++)
        if (!rq[i] || gnt[i]) pdata[i] = 4'($urandom);

      if (r) begin
        m_own = -1; m_cnt = 0; m_ptr = 0;
      end else if (m_own < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && rq[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N;
            m_cnt = 0;
            found = 1'b1;
          end
        end
      end else begin
        if (w) m_cnt++;
        if (!rq[m_own] || m_cnt == MB) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end
      end
    end

    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fifo_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fifo_entry[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
